commit_queue: RTL and testbench



---
 rtl/commit_queue.sv | 153 +++++++++++++++
 tb/tb_commit_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_queue.sv
// commit_queue: in-order retire queue between issue and commit.
// Entries are tagged with their slot index as transaction ID, collect
// functional-unit writebacks, and retire from the head on commit acks.

package commit_queue_pkg;
    localparam int XLEN          = 32;
    localparam int TRANS_ID_BITS = 3;

    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL, FU_MULT, FU_CSR, ACCEL
    } fu_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [3:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;   // stored: writeback done
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int NR_ENTRIES      = 1 << TRANS_ID_BITS,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_WB_PORTS     = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  scoreboard_entry_t                           issue_instr_i,
    input  logic                                        issue_valid_i,
    output logic                                        issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wbdata_i,
    input  exception_t [NR_WB_PORTS-1:0]                ex_i,
    input  logic [NR_WB_PORTS-1:0]                      wt_valid_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]     commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i,
    output logic [$clog2(NR_ENTRIES):0]                 usage_o
);
    localparam int UW = $clog2(NR_ENTRIES) + 1;

    scoreboard_entry_t          r_mem [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]      r_busy;
    logic [TRANS_ID_BITS-1:0]   r_head;
    logic [TRANS_ID_BITS-1:0]   r_tail;
    logic [UW-1:0]              r_usage;

    logic                       w_issue;
    scoreboard_entry_t          w_new;
    logic [TRANS_ID_BITS-1:0]   w_cidx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] w_retire;
    logic [UW-1:0]              w_ret_cnt;
    logic                       w_run;

    // Ready/ID come from registers and flush only; no path from issue_valid_i.
    assign issue_ready_o    = (r_usage < UW'(NR_ENTRIES)) && !flush_i;
    assign issue_trans_id_o = r_tail;
    assign usage_o          = r_usage;
    assign w_issue          = issue_valid_i && issue_ready_o;

    // Entry written at the tail: result/ex are cleared until writeback.
    always_comb begin
        w_new          = issue_instr_i;
        w_new.valid    = 1'b0;
        w_new.trans_id = r_tail;
        w_new.result   = '0;
        w_new.ex       = '0;
    end

    // Head-relative slots, commit view, and the leading run of accepted acks.
    always_comb begin
        w_ret_cnt = '0;
        w_retire  = '0;
        w_run     = 1'b1;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_cidx[i]                = r_head + TRANS_ID_BITS'(i);
            commit_instr_o[i]        = r_mem[w_cidx[i]];
            commit_instr_o[i].valid  = r_mem[w_cidx[i]].valid && r_busy[w_cidx[i]];
            // Acks to non-busy entries are ignored and end the run.
            if (w_run && commit_ack_i[i] && r_busy[w_cidx[i]]) begin
                w_retire[i] = 1'b1;
                w_ret_cnt   = w_ret_cnt + 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Queue state: flush beats everything; writeback ports are applied in
    // ascending order so the highest index wins on a shared ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_usage <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_busy  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_usage <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) r_mem[i].valid <= 1'b0;
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wt_valid_i[p] && r_busy[trans_id_i[p]]) begin
                    r_mem[trans_id_i[p]].valid  <= 1'b1;
                    r_mem[trans_id_i[p]].result <= wbdata_i[p];
                    r_mem[trans_id_i[p]].ex     <= ex_i[p];
                end
            end
            if (w_issue) begin
                r_mem[r_tail]  <= w_new;
                r_busy[r_tail] <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (w_retire[i]) begin
                    r_busy[w_cidx[i]]      <= 1'b0;
                    r_mem[w_cidx[i]].valid <= 1'b0;
                end
            end
            r_head  <= r_head + TRANS_ID_BITS'(w_ret_cnt);
            r_usage <= r_usage + UW'(w_issue) - w_ret_cnt;
        end
    end

    // Protocol check: the commit stage must not ack an entry that is not busy.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                assert (!(commit_ack_i[i] && !r_busy[w_cidx[i]]))
                else $error("commit_queue: ack on port %0d to non-busy entry", i);
            end
        end
    end

endmodule

// File: tb/tb_commit_queue.sv
// Self-checking bench for commit_queue: directed scenarios followed by
// random traffic, compared every cycle against a behavioural model.
module tb_commit_queue;
    import commit_queue_pkg::*;

    localparam int NE = 8;
    localparam int NC = 2;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic iv = 1'b0;
    scoreboard_entry_t instr = '0;
    logic [NW-1:0][TRANS_ID_BITS-1:0] tid = '0;
    logic [NW-1:0][XLEN-1:0] wd = '0;
    exception_t [NW-1:0] exi = '0;
    logic [NW-1:0] wtv = '0;
    logic [NC-1:0] ack = '0;

    logic ready;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    scoreboard_entry_t [NC-1:0] commit;
    logic [3:0] usage;

    commit_queue #(.NR_ENTRIES(NE), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .issue_instr_i(instr), .issue_valid_i(iv), .issue_ready_o(ready),
        .issue_trans_id_o(trans_id_o),
        .trans_id_i(tid), .wbdata_i(wd), .ex_i(exi), .wt_valid_i(wtv),
        .commit_instr_o(commit), .commit_ack_i(ack), .usage_o(usage)
    );

    always #5 clk = ~clk;

    // Behavioural model: slots indexed by ID, plus head/tail/occupancy.
    scoreboard_entry_t m_ent [NE];
    bit m_busy [NE];
    int m_head, m_tail, m_usage;
    int n_chk = 0, n_pass = 0;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic scoreboard_entry_t m_view(int i);
        scoreboard_entry_t e;
        int s = (m_head + i) % NE;
        e = m_ent[s];
        e.valid = e.valid && m_busy[s];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin m_ent[i] = '0; m_busy[i] = 0; end
        m_head = 0; m_tail = 0; m_usage = 0;
    endtask

    task automatic model_step();
        int n;
        bit issued;
        scoreboard_entry_t e;
        if (!rst_n) begin model_reset(); return; end
        if (flush) begin
            for (int i = 0; i < NE; i++) begin m_busy[i] = 0; m_ent[i].valid = 1'b0; end
            m_head = 0; m_tail = 0; m_usage = 0;
            return;
        end
        issued = iv && (m_usage < NE);
        n = 0;
        while (n < NC && ack[n] && m_busy[(m_head + n) % NE]) n++;
        for (int p = 0; p < NW; p++)
            if (wtv[p] && m_busy[tid[p]]) begin
                m_ent[tid[p]].valid  = 1'b1;
                m_ent[tid[p]].result = wd[p];
                m_ent[tid[p]].ex     = exi[p];
            end
        if (issued) begin
            e = instr; e.valid = 1'b0; e.trans_id = 3'(m_tail); e.result = '0; e.ex = '0;
            m_ent[m_tail] = e; m_busy[m_tail] = 1; m_tail = (m_tail + 1) % NE;
        end
        for (int k = 0; k < n; k++) begin
            m_busy[(m_head + k) % NE] = 0;
            m_ent[(m_head + k) % NE].valid = 1'b0;
        end
        m_head = (m_head + n) % NE;
        m_usage = m_usage + int'(issued) - n;
    endtask

    task automatic check_out();
        chk("usage", usage, m_usage);
        chk("ready", ready, (m_usage < NE) && !flush);
        chk("trans_id", trans_id_o, m_tail);
        for (int i = 0; i < NC; i++) chk($sformatf("commit%0d", i), commit[i], m_view(i));
    endtask

    // Inputs are set just after a rising edge; check at the falling edge,
    // then advance the model with the inputs the DUT sampled.
    task automatic cycle();
        @(negedge clk);
        check_out();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        iv = 0; wtv = '0; ack = '0; flush = 0; exi = '0;
    endtask

    task automatic rand_instr();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        instr = r[$bits(scoreboard_entry_t)-1:0];
    endtask

    task automatic do_flush();
        idle(); flush = 1; cycle(); idle();
    endtask

    task automatic issue_n(int n);
        for (int i = 0; i < n; i++) begin rand_instr(); iv = 1; cycle(); end
        idle();
    endtask

    initial begin
        model_reset();
        cycle(); cycle();
        chk("rst_usage", usage, 0);
        chk("rst_ready", ready, 1);
        chk("rst_commit0", commit[0], '0);
        rst_n = 1;
        cycle();

        // Single issue, writeback, ack
        rand_instr(); instr.fu = FU_ALU; iv = 1;
        chk("t1_id", trans_id_o, 0);
        cycle(); idle();
        chk("t1_usage", usage, 1);
        chk("t1_not_valid", commit[0].valid, 0);
        tid[0] = 3'd0; wd[0] = 32'hDEAD; wtv = 4'b0001; cycle(); idle();
        chk("t1_wb_valid", commit[0].valid, 1);
        chk("t1_wb_result", commit[0].result, 32'hDEAD);
        ack = 2'b01; cycle(); idle();
        chk("t1_retire_usage", usage, 0);
        chk("t1_retire_valid", commit[0].valid, 0);

        // Fill, drain two per cycle, wrap
        do_flush();
        issue_n(8);
        chk("fill_ready", ready, 0);
        chk("fill_usage", usage, 8);
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < NW; p++) begin tid[p] = 3'(c * 4 + p); wd[p] = $urandom; end
            wtv = 4'hF; cycle();
        end
        idle();
        for (int c = 0; c < 4; c++) begin ack = 2'b11; cycle(); end
        idle();
        chk("drain_usage", usage, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_id%0d", i), trans_id_o, i);
            rand_instr(); iv = 1; cycle();
        end
        idle();

        // Out-of-order writeback, ack on port 1 only
        do_flush();
        issue_n(2);
        tid[0] = 3'd1; wd[0] = 32'h1111; wtv = 4'b0001; cycle(); idle();
        chk("ooo_p1_valid", commit[1].valid, 1);
        chk("ooo_p0_valid", commit[0].valid, 0);
        ack = 2'b10; cycle(); idle();
        chk("ooo_no_retire", usage, 2);

        // Collision on ID 2: port 3 wins, with exception
        issue_n(1);
        tid[0] = 3'd0; wd[0] = 32'h5; wtv = 4'b0001; cycle(); idle();
        ack = 2'b11; cycle(); idle();
        tid[0] = 3'd2; wd[0] = 32'h11; tid[3] = 3'd2; wd[3] = 32'h33;
        exi[3].valid = 1'b1; exi[3].cause = 32'd2; wtv = 4'b1001; cycle(); idle();
        chk("col_result", commit[0].result, 32'h33);
        chk("col_cause", commit[0].ex.cause, 2);
        chk("col_exvalid", commit[0].ex.valid, 1);

        // Flush against concurrent issue, writeback and ack
        do_flush();
        issue_n(5);
        flush = 1; rand_instr(); iv = 1; tid[1] = 3'd3; wd[1] = 32'h77; wtv = 4'b0010; ack = 2'b11;
        cycle(); idle();
        chk("fl_usage", usage, 0);
        chk("fl_p0", commit[0].valid, 0);
        chk("fl_p1", commit[1].valid, 0);
        chk("fl_id", trans_id_o, 0);

        // Full queue: issue+ack while full issues nothing; ack frees one slot
        issue_n(8);
        rand_instr(); iv = 1; ack = 2'b01; cycle(); idle();
        chk("full_usage", usage, 7);
        chk("full_ready", ready, 1);
        chk("full_id", trans_id_o, 0);
        rand_instr(); iv = 1; cycle(); idle();
        chk("full_again", ready, 0);

        // Asynchronous reset between edges
        #2 rst_n = 0;
        #1;
        chk("arst_usage", usage, 0);
        chk("arst_ready", ready, 1);
        chk("arst_commit0", commit[0], '0);
        model_reset();
        cycle();
        rst_n = 1;
        cycle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            flush = ($urandom_range(0, 99) < 3);
            iv = ($urandom_range(0, 99) < 60);
            rand_instr();
            for (int p = 0; p < NW; p++) begin
                wtv[p] = ($urandom_range(0, 99) < 35);
                tid[p] = 3'($urandom_range(0, NE - 1));
                wd[p]  = $urandom;
                exi[p] = '0;
                exi[p].valid = ($urandom_range(0, 9) == 0);
                exi[p].cause = $urandom_range(0, 15);
            end
            for (int i = 0; i < NC; i++)
                ack[i] = m_busy[(m_head + i) % NE] && ($urandom_range(0, 99) < 55);
            cycle();
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
